// File: rtl/pipe_sched.sv
// Round-robin scheduler sharing one fixed-latency, enable-gated pipeline among
// NUM_REQ requesters; a shadow valid/tag chain labels each result with its source.
module pipe_sched #(
   parameter int unsigned NUM_REQ  = 4,
   parameter int unsigned WIDTH    = 16,
   parameter int unsigned LENGTH   = 3,
   parameter int unsigned ID_WIDTH = 2,
   localparam int unsigned OCC_W   = $clog2(LENGTH + 1)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ*WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]       grant,
   output logic                     pipe_en,
   output logic [WIDTH-1:0]         pipe_in,
   input  logic [WIDTH-1:0]         pipe_out,
   output logic                     out_valid,
   output logic [ID_WIDTH-1:0]      out_id,
   output logic [WIDTH-1:0]         out_data,
   input  logic                     out_ready,
   output logic                     busy,
   output logic [OCC_W-1:0]         occupancy
);

   localparam logic [ID_WIDTH-1:0] LAST_ID = ID_WIDTH'(NUM_REQ - 1);

   logic [LENGTH-1:0]               vld_q, vld_d;
   logic [LENGTH-1:0][ID_WIDTH-1:0] tag_q, tag_d;
   logic [ID_WIDTH-1:0]             rr_q, rr_d;
   logic [OCC_W-1:0]                occ_q, occ_d;

   logic                            found;
   logic [ID_WIDTH-1:0]             win;
   logic                            any_grant;
   logic                            consume;

   // Only a real result waiting on a busy consumer freezes the pipe; bubbles never do.
   assign pipe_en = !(vld_q[LENGTH-1] && !out_ready);
   assign consume = vld_q[LENGTH-1] && out_ready;

   // Rotating priority as two ascending passes: requesters at or above rr_q
   // first, then the wrapped-around ones below it.
   always_comb begin
      found = 1'b0;
      win   = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (!found && req[i] && (i >= 32'(rr_q))) begin
            found = 1'b1;
            win   = ID_WIDTH'(i);
         end
      end
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (!found && req[i]) begin
            found = 1'b1;
            win   = ID_WIDTH'(i);
         end
      end
   end

   // Grant is also masked while reset is held so nothing is issued into a clearing pipe.
   always_comb begin
      grant   = '0;
      pipe_in = '0;
      if (rst && pipe_en && found) begin
         for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (ID_WIDTH'(i) == win) begin
               grant[i] = 1'b1;
               pipe_in  = req_data[i*WIDTH +: WIDTH];
            end
         end
      end
   end

   assign any_grant = |grant;

   always_comb begin
      rr_d = rr_q;
      if (any_grant) begin
         rr_d = (win == LAST_ID) ? '0 : win + ID_WIDTH'(1);
      end
   end

   always_comb begin
      vld_d = vld_q;
      tag_d = tag_q;
      if (pipe_en) begin
         vld_d[0] = any_grant;
         tag_d[0] = any_grant ? win : '0;
         for (int unsigned i = 1; i < LENGTH; i++) begin
            vld_d[i] = vld_q[i-1];
            tag_d[i] = tag_q[i-1];
         end
      end
   end

   always_comb begin
      occ_d = occ_q;
      if (any_grant && !consume) begin
         occ_d = occ_q + OCC_W'(1);
      end else if (consume && !any_grant) begin
         occ_d = occ_q - OCC_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_q <= '0;
         tag_q <= '0;
         rr_q  <= '0;
         occ_q <= '0;
      end else begin
         vld_q <= vld_d;
         tag_q <= tag_d;
         rr_q  <= rr_d;
         occ_q <= occ_d;
      end
   end

   assign out_valid = vld_q[LENGTH-1];
   assign out_id    = tag_q[LENGTH-1];
   assign out_data  = pipe_out;
   assign busy      = (occ_q != '0);
   assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_sched.sv
// Bench for pipe_sched: identity pipeline model, latency-countdown scoreboard
// checked every cycle, plus directed arbitration/stall/reset scenarios.
module tb_pipe_sched;

   localparam int NR  = 4;
   localparam int W   = 16;
   localparam int L   = 3;
   localparam int IDW = 2;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic [NR-1:0]     req = '0;
   logic [NR*W-1:0]   req_data = '0;
   logic [NR-1:0]     grant;
   logic              pipe_en;
   logic [W-1:0]      pipe_in;
   logic [W-1:0]      pipe_out;
   logic              out_valid;
   logic [IDW-1:0]    out_id;
   logic [W-1:0]      out_data;
   logic              out_ready = 1'b1;
   logic              busy;
   logic [1:0]        occupancy;

   pipe_sched #(.NUM_REQ(NR), .WIDTH(W), .LENGTH(L), .ID_WIDTH(IDW)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .req_data  (req_data),
      .grant     (grant),
      .pipe_en   (pipe_en),
      .pipe_in   (pipe_in),
      .pipe_out  (pipe_out),
      .out_valid (out_valid),
      .out_id    (out_id),
      .out_data  (out_data),
      .out_ready (out_ready),
      .busy      (busy),
      .occupancy (occupancy)
   );

   always #5 clk = ~clk;

   // Shared datapath: identity, enable-gated, deliberately not reset.
   logic [W-1:0] dp [L];
   always @(posedge clk) begin
      if (pipe_en) begin
         dp[0] <= pipe_in;
         for (int i = 1; i < L; i++) dp[i] <= dp[i-1];
      end
   end
   assign pipe_out = dp[L-1];

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
   endtask

   typedef struct {
      logic [IDW-1:0] id;
      logic [W-1:0]   data;
      int             cnt;
   } item_t;

   item_t          sb[$];
   item_t          it;
   logic [IDW-1:0] m_rr = '0;
   logic           exp_v;
   logic           exp_stall;
   logic [NR-1:0]  exp_g;
   int             win;
   int             mi;

   // Scoreboard: each grant pushes {id,data} with a countdown to the output stage.
   always @(negedge clk) begin
      if (!rst) begin
         sb.delete();
         m_rr = '0;
      end else begin
         exp_v = (sb.size() != 0) && (sb[0].cnt == 0);
         check("out_valid", 32'(out_valid), 32'(exp_v));
         if (exp_v) begin
            check("out_id", 32'(out_id), 32'(sb[0].id));
            check("out_data", 32'(out_data), 32'(sb[0].data));
         end
         exp_stall = exp_v && !out_ready;
         check("pipe_en", 32'(pipe_en), 32'(!exp_stall));
         check("occupancy", 32'(occupancy), 32'(sb.size()));
         check("busy", 32'(busy), 32'(sb.size() != 0));
         exp_g = '0;
         win   = -1;
         if (!exp_stall) begin
            for (int k = 0; k < NR; k++) begin
               mi = (int'(m_rr) + k) % NR;
               if (win < 0 && req[mi]) win = mi;
            end
         end
         if (win >= 0) exp_g[win] = 1'b1;
         check("grant", 32'(grant), 32'(exp_g));
         if (win >= 0) check("pipe_in", 32'(pipe_in), 32'(req_data[win*W +: W]));
         if (!exp_stall) begin
            if (exp_v && out_ready) void'(sb.pop_front());
            foreach (sb[i]) sb[i].cnt = sb[i].cnt - 1;
            if (win >= 0) begin
               it.id   = IDW'(win);
               it.data = req_data[win*W +: W];
               it.cnt  = L - 1;
               sb.push_back(it);
               m_rr = IDW'((win + 1) % NR);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Asserts reset between clock edges and checks outputs before any edge occurs.
   task automatic do_reset();
      #2 rst = 1'b0;
      #1;
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_occupancy", 32'(occupancy), 0);
      check("rst_grant", 32'(grant), 0);
      check("rst_pipe_en", 32'(pipe_en), 1);
      check("rst_pipe_in", 32'(pipe_in), 0);
      check("rst_out_id", 32'(out_id), 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
   endtask

   typedef struct {
      logic [NR-1:0] rq;
      logic          rdy;
      logic [NR-1:0] g;
      logic          en;
      logic          v;
   } bub_t;

   bub_t bub [9];
   int   lat;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      bub[0] = '{4'b0100, 1'b0, 4'b0100, 1'b1, 1'b0};
      bub[1] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0};
      bub[2] = '{4'b0100, 1'b0, 4'b0100, 1'b1, 1'b0};
      bub[3] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1};
      bub[4] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1};
      bub[5] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 1'b1};
      bub[6] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0};
      bub[7] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1};
      bub[8] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 1'b1};

      #6;
      do_reset();

      // Single request: latency LENGTH, then rr_ptr points at requester 1.
      req_data[15:0] = 16'h1234;
      req = 4'b0001;
      @(negedge clk);
      check("single_grant", 32'(grant), 32'h1);
      step();
      req = '0;
      lat = 0;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (lat == 0 && out_valid) begin
            lat = c;
            check("single_id", 32'(out_id), 0);
            check("single_data", 32'(out_data), 32'h1234);
         end
         step();
      end
      check("single_latency", 32'(lat), 3);
      req = 4'b0011;
      @(negedge clk);
      check("rr_after_single", 32'(grant), 32'h2);
      step();
      req = '0;

      // Fairness: all requesters held, grants rotate and tags follow 3 cycles later.
      do_reset();
      req_data = {16'hD003, 16'hD002, 16'hD001, 16'hD000};
      req = 4'hF;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         check("fair_grant", 32'(grant), 32'(1 << (k % 4)));
         if (k >= 3) begin
            check("fair_occ", 32'(occupancy), 3);
            check("fair_id", 32'(out_id), 32'((k - 3) % 4));
         end
         step();
      end

      // Back-pressure on a full pipe: everything freezes, then drains in order.
      out_ready = 1'b0;
      for (int s = 0; s < 5; s++) begin
         @(negedge clk);
         check("bp_pipe_en", 32'(pipe_en), 0);
         check("bp_grant", 32'(grant), 0);
         check("bp_out_id", 32'(out_id), 1);
         check("bp_out_data", 32'(out_data), 32'hD001);
         step();
      end
      out_ready = 1'b1;
      for (int j = 0; j < 4; j++) begin
         @(negedge clk);
         check("bp_resume_valid", 32'(out_valid), 1);
         check("bp_resume_id", 32'(out_id), 32'((1 + j) % 4));
         step();
      end
      req = '0;
      repeat (4) step();

      // Bubbles: only a real result blocked by out_ready=0 stalls the pipe.
      for (int k = 0; k < 9; k++) begin
         req = bub[k].rq;
         out_ready = bub[k].rdy;
         req_data[47:32] = (k < 2) ? 16'hBEEF : 16'hCAFE;
         @(negedge clk);
         check("bub_grant", 32'(grant), 32'(bub[k].g));
         check("bub_pipe_en", 32'(pipe_en), 32'(bub[k].en));
         check("bub_valid", 32'(out_valid), 32'(bub[k].v));
         if (k == 3) check("bub_data_first", 32'(out_data), 32'hBEEF);
         if (k == 7) check("bub_data_second", 32'(out_data), 32'hCAFE);
         step();
      end
      req = '0;
      out_ready = 1'b1;
      repeat (4) step();

      // Wrap: rr_ptr 3 -> 0 -> 1.
      do_reset();
      req = 4'b0100;
      @(negedge clk);
      check("wrap_g2", 32'(grant), 32'h4);
      step();
      req = 4'b1001;
      @(negedge clk);
      check("wrap_g3", 32'(grant), 32'h8);
      step();
      @(negedge clk);
      check("wrap_g0", 32'(grant), 32'h1);
      step();
      req = 4'hF;
      @(negedge clk);
      check("wrap_g1", 32'(grant), 32'h2);
      step();
      req = '0;
      repeat (4) step();

      // Async reset mid-stream with a full pipe; stale datapath contents stay masked.
      req = 4'hF;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (k == 3) check("pre_rst_occ", 32'(occupancy), 3);
         step();
      end
      do_reset();
      @(negedge clk);
      check("post_rst_grant", 32'(grant), 32'h1);
      step();
      req = '0;
      for (int j = 1; j <= 3; j++) begin
         @(negedge clk);
         check("post_rst_valid", 32'(out_valid), 32'(j == 3));
         if (j == 3) check("post_rst_id", 32'(out_id), 0);
         step();
      end

      // Random traffic against the scoreboard.
      for (int k = 0; k < 300; k++) begin
         req = NR'($urandom);
         for (int i = 0; i < NR; i++) req_data[i*W +: W] = W'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         step();
      end
      req = '0;
      out_ready = 1'b1;
      repeat (8) step();
      @(negedge clk);
      check("drain_occ", 32'(occupancy), 0);
      check("drain_busy", 32'(busy), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
